// File: rtl/universal_counter_pkg.sv
// universal_counter_pkg: shared direction encodings and prescaler width for universal_counter
package universal_counter_pkg;
  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;
  localparam int   PRESCALE_W = 16;
endpackage

// File: rtl/universal_counter_prescaler.sv
// universal_counter_prescaler: clock-enable divider; ports clk, rst_n, en, clr (load), prescale in; tick, prescale_reg out
module universal_counter_prescaler
  import universal_counter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic [PRESCALE_W-1:0] prescale_reg
);
  logic [PRESCALE_W-1:0] prescale_reg_q, prescale_reg_d;
  always_comb begin
    tick = en && !clr && (prescale_reg_q >= prescale);
    prescale_reg_d = (clr || tick) ? '0 : en ? prescale_reg_q + 1'b1 : prescale_reg_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prescale_reg_q <= '0;
    else prescale_reg_q <= prescale_reg_d;
  assign prescale_reg = prescale_reg_q;
endmodule

// File: rtl/universal_counter.sv
// universal_counter: prescaled up/down counter with load, auto-reload and done pulse; ports clk, rst_n, en, load, mode, auto_reload, prescale, preset in; count, done out
module universal_counter
  import universal_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      preset,
  output logic [WIDTH-1:0]      count,
  output logic                  done
);
  logic [PRESCALE_W-1:0] prescale_reg;
  logic                  tick, step, at_term;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  done_q, done_d, halted_q, halted_d;
  universal_counter_prescaler u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clr          (load),
    .prescale     (prescale),
    .tick         (tick),
    .prescale_reg (prescale_reg)
  );
  always_comb begin
    at_term  = (mode == MODE_DOWN) ? (count_q == '0) : (count_q == preset);
    step     = tick && !halted_q;
    done_d   = step && at_term;
    halted_d = load ? 1'b0 : (done_d && !auto_reload) ? 1'b1 : halted_q;
    count_d  = load ? preset
             : !step ? count_q
             : !at_term ? ((mode == MODE_DOWN) ? count_q - 1'b1 : count_q + 1'b1)
             : !auto_reload ? count_q
             : (mode == MODE_DOWN) ? preset : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q  <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  assign count = count_q;
  assign done  = done_q;
endmodule

// File: tb/tb_universal_counter.sv
// tb_universal_counter: directed self-checking bench for universal_counter
module tb_universal_counter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic        auto_reload = 1'b0;
  logic [15:0] prescale = '0;
  logic [7:0]  preset = '0;
  logic [7:0]  count;
  logic        done;
  int          compared = 0;
  int          mismatched = 0;
  universal_counter #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .load        (load),
    .mode        (mode),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .preset      (preset),
    .count       (count),
    .done        (done)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    en = 1'b0;
    load = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask
  task automatic do_load();
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    compared++;
    if (count !== 8'h00 || done !== 1'b0 || dut.prescale_reg !== 16'h0) begin
      $display("FAIL reset: count=%h done=%b preg=%h, expected 00/0/0000", count, done, dut.prescale_reg);
      mismatched++;
    end
  endtask
  task automatic test_down_reload();
    int n;
    logic [7:0] ec;
    logic ed;
    do_reset();
    mode = 1'b1; auto_reload = 1'b1; prescale = 16'd2; preset = 8'h05;
    do_load();
    compared++;
    if (count !== 8'h05 || dut.prescale_reg !== 16'h0) begin
      $display("FAIL down_load: count=%h preg=%h, expected 05/0000", count, dut.prescale_reg);
      mismatched++;
    end
    en = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      cyc();
      n = k / 3;
      ec = 8'(5 - (n % 6));
      ed = (k % 3 == 0) && (n % 6 == 0);
      compared++;
      if (count !== ec || done !== ed || dut.prescale_reg !== 16'(k % 3)) begin
        $display("FAIL down_reload k=%0d: count=%h done=%b preg=%h, expected %h/%b/%h", k, count, done, dut.prescale_reg, ec, ed, 16'(k % 3));
        mismatched++;
      end
    end
    en = 1'b0;
  endtask
  task automatic test_up_stop();
    logic [7:0] ec [6] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03};
    logic       ed [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    mode = 1'b0; auto_reload = 1'b0; prescale = 16'd0; preset = 8'h03;
    do_load();
    compared++;
    if (count !== 8'h03 || done !== 1'b0) begin
      $display("FAIL up_load: count=%h done=%b, expected 03/0", count, done);
      mismatched++;
    end
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      compared++;
      if (count !== 8'h03 || done !== (k == 1)) begin
        $display("FAIL up_stop_loaded k=%0d: count=%h done=%b, expected 03/%b", k, count, done, k == 1);
        mismatched++;
      end
    end
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      compared++;
      if (count !== ec[k] || done !== ed[k]) begin
        $display("FAIL up_stop_from0 k=%0d: count=%h done=%b, expected %h/%b", k, count, done, ec[k], ed[k]);
        mismatched++;
      end
    end
    en = 1'b0;
  endtask
  task automatic test_down_full();
    do_reset();
    mode = 1'b1; auto_reload = 1'b1; prescale = 16'd0; preset = 8'hFF;
    do_load();
    en = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      cyc();
      compared++;
      if (count !== 8'(255 - (k % 256)) || done !== (k % 256 == 0)) begin
        $display("FAIL down_full k=%0d: count=%h done=%b, expected %h/%b", k, count, done, 8'(255 - (k % 256)), k % 256 == 0);
        mismatched++;
      end
    end
    en = 1'b0;
  endtask
  task automatic test_en_freeze();
    do_reset();
    mode = 1'b1; auto_reload = 1'b1; prescale = 16'd3; preset = 8'h05;
    do_load();
    en = 1'b1;
    cyc();
    cyc();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      compared++;
      if (count !== 8'h05 || dut.prescale_reg !== 16'd2 || done !== 1'b0) begin
        $display("FAIL en_freeze k=%0d: count=%h preg=%h done=%b, expected 05/0002/0", k, count, dut.prescale_reg, done);
        mismatched++;
      end
    end
    en = 1'b1;
    cyc();
    compared++;
    if (count !== 8'h05 || dut.prescale_reg !== 16'd3) begin
      $display("FAIL en_resume1: count=%h preg=%h, expected 05/0003", count, dut.prescale_reg);
      mismatched++;
    end
    cyc();
    compared++;
    if (count !== 8'h04 || dut.prescale_reg !== 16'd0) begin
      $display("FAIL en_resume2: count=%h preg=%h, expected 04/0000", count, dut.prescale_reg);
      mismatched++;
    end
    en = 1'b0;
  endtask
  task automatic test_load_priority();
    do_reset();
    mode = 1'b1; auto_reload = 1'b1; prescale = 16'd1; preset = 8'h07;
    en = 1'b1;
    cyc();
    compared++;
    if (count !== 8'h00 || dut.prescale_reg !== 16'd1) begin
      $display("FAIL load_setup: count=%h preg=%h, expected 00/0001", count, dut.prescale_reg);
      mismatched++;
    end
    load = 1'b1;
    cyc();
    load = 1'b0;
    compared++;
    if (count !== 8'h07 || dut.prescale_reg !== 16'd0 || done !== 1'b0) begin
      $display("FAIL load_priority: count=%h preg=%h done=%b, expected 07/0000/0", count, dut.prescale_reg, done);
      mismatched++;
    end
    cyc();
    compared++;
    if (count !== 8'h07 || dut.prescale_reg !== 16'd1 || done !== 1'b0) begin
      $display("FAIL load_after: count=%h preg=%h done=%b, expected 07/0001/0", count, dut.prescale_reg, done);
      mismatched++;
    end
    cyc();
    compared++;
    if (count !== 8'h06 || done !== 1'b0) begin
      $display("FAIL load_step: count=%h done=%b, expected 06/0", count, done);
      mismatched++;
    end
    en = 1'b0;
  endtask
  task automatic test_async_reset();
    do_reset();
    mode = 1'b1; auto_reload = 1'b1; prescale = 16'd0; preset = 8'h02;
    do_load();
    en = 1'b1;
    cyc();
    cyc();
    cyc();
    compared++;
    if (count !== 8'h02 || done !== 1'b1) begin
      $display("FAIL async_setup: count=%h done=%b, expected 02/1", count, done);
      mismatched++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (count !== 8'h00 || done !== 1'b0 || dut.prescale_reg !== 16'h0) begin
      $display("FAIL async_reset: count=%h done=%b preg=%h, expected 00/0/0000", count, done, dut.prescale_reg);
      mismatched++;
    end
    en = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      compared++;
      if (count !== 8'h00 || done !== 1'b0) begin
        $display("FAIL async_hold k=%0d: count=%h done=%b, expected 00/0", k, count, done);
        mismatched++;
      end
    end
  endtask
  initial begin
    cyc();
    test_reset();
    test_down_reload();
    test_up_stop();
    test_down_full();
    test_en_freeze();
    test_load_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
